icache: RTL
===========

ICACHE -- requirements
Module: icache

Interface
REQ-001 Parameter INDEX_W, default 6, log2 of number of lines (one 32-bit word per line, direct-mapped).
REQ-002 Parameter ADDR_W, default 32, fetch address width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 rdy  input  1  global pause; low freezes all internal state.
REQ-006 if_req_i  input  1  IF fetch request, level, held until served.
REQ-007 if_addr_i  input  ADDR_W  fetch address; bits [1:0] ignored.
REQ-008 flush_i  input  1  invalidate all lines (fence.i).
REQ-009 inst_valid_o  output  1  inst_o valid for current if_addr_i.
REQ-010 inst_o  output  32  fetched instruction.
REQ-011 mem_req_o  output  1  miss request to memory controller, level.
REQ-012 mem_addr_o  output  ADDR_W  word-aligned miss address (bits [1:0]=0).
REQ-013 mem_done_i  input  1  one-cycle pulse, mem_inst_i valid.
REQ-014 mem_inst_i  input  32  refill word from memory controller.

Function
REQ-015 Address split: index = addr[INDEX_W+1:2], tag = addr[ADDR_W-1:INDEX_W+2]; storage per line: valid bit, tag, 32-bit data.
REQ-016 States: IDLE, MISS, RESP; reset state IDLE.
REQ-017 IDLE, if_req_i=1, line valid and tag match: inst_valid_o=1 and inst_o=line data combinationally in the same cycle; state stays IDLE.
REQ-018 IDLE, if_req_i=1, miss: latch word address; next cycle state MISS, mem_req_o=1, mem_addr_o=latched address.
REQ-019 MISS: mem_req_o and mem_addr_o held constant until mem_done_i; on mem_done_i write valid/tag/data into indexed line, register word, go RESP, drop mem_req_o in RESP.
REQ-020 RESP (one cycle): inst_valid_o=1 with registered word only if if_req_i=1 and if_addr_i word address equals latched address; otherwise line is filled, no response; always return IDLE.
REQ-021 Miss penalty seen by IF: memory latency + 1 cycle (RESP).
REQ-022 inst_valid_o is 0 in MISS and whenever if_req_i=0; inst_o is 0 when inst_valid_o=0.
REQ-023 flush_i in IDLE/RESP: all valid bits cleared at the next edge; a hit lookup in the flush cycle is treated as miss.
REQ-024 flush_i in MISS: outstanding request completes (mem_req_o held to mem_done_i), refill word discarded (not written), no response in RESP.
REQ-025 flush_i coinciding with mem_done_i: flush wins, line not written.
REQ-026 IF redirect (if_addr_i change) during MISS: no abort; refill proceeds; new address is looked up after RESP.
REQ-027 rdy=0: state, storage, latched address frozen; outputs hold; mem_done_i while rdy=0 is not expected (controller shares rdy).

Reset
REQ-028 rst=1: state IDLE, all valid bits 0, mem_req_o=0, mem_addr_o=0, inst_valid_o=0, inst_o=0; data/tag arrays need not be cleared.
REQ-029 rst overrides rdy and flush_i; reset mid-MISS abandons the request, mem_req_o low next cycle.

Configuration
REQ-030 Macro ICACHE_STAT_EN: when defined, adds outputs hit_cnt_o (32) and miss_cnt_o (32), incremented once per IDLE hit response and once per IDLE->MISS transition, cleared by rst, wrap at 2^32, frozen when rdy=0.
REQ-031 Without ICACHE_STAT_EN: ports and counters absent; functional behaviour identical.

Structure
REQ-032 Shared package/defines file holds state encodings (IDLE/MISS/RESP), default INDEX_W, and reuses existing InstAddrBus/InstBus widths.
REQ-033 One sub-module, icache_tag_ram: valid/tag/data storage with combinational read, synchronous write, single-cycle clear-all.

Verification
REQ-034 Cold fetch 0x0000_0000, memory returns 0x0000_0013 after 4 cycles -> mem_req_o high 4 cycles, addr 0x0, inst_valid_o in cycle 6 with 0x00000013.
REQ-035 Repeat fetch 0x0 -> inst_valid_o same cycle, mem_req_o stays 0.
REQ-036 Conflict: fetch 0x0 then 0x100 (INDEX_W=6, same index) then 0x0 -> three misses, second refill evicts first.
REQ-037 flush_i pulsed during MISS for 0x4 -> mem_done_i accepted, no response, next fetch 0x4 misses again.
REQ-038 IF redirects 0x8 -> 0x20 during MISS for 0x8 -> no response for 0x8, line 0x8 valid afterward, 0x20 then misses.
REQ-039 rdy low 3 cycles mid-MISS, rst asserted mid-MISS -> outputs frozen while rdy low; after rst mem_req_o=0, all lookups miss; with ICACHE_STAT_EN counters match hit/miss totals.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared types and widths for the direct-mapped instruction cache.
// Optional statistics counters are enabled with the ICACHE_STAT_EN macro.
package icache_pkg;

  localparam int INST_ADDR_W     = 32;  // InstAddrBus width
  localparam int INST_W          = 32;  // InstBus width
  localparam int DEFAULT_INDEX_W = 6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MISS = 2'd1,
    S_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/icache_tag_ram.sv
// Valid/tag/data storage: combinational read, synchronous write, one-cycle clear of all valid bits.
module icache_tag_ram
  import icache_pkg::*;
#(
  parameter int INDEX_W = DEFAULT_INDEX_W,
  parameter int TAG_W   = INST_ADDR_W - DEFAULT_INDEX_W - 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               clear,
  input  logic               we,
  input  logic [INDEX_W-1:0] waddr,
  input  logic [TAG_W-1:0]   wtag,
  input  logic [INST_W-1:0]  wdata,
  input  logic [INDEX_W-1:0] raddr,
  output logic               rvalid,
  output logic [TAG_W-1:0]   rtag,
  output logic [INST_W-1:0]  rdata
);

  localparam int DEPTH = 1 << INDEX_W;

  logic [DEPTH-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_mem  [DEPTH];
  logic [INST_W-1:0] data_mem [DEPTH];

  // Clear beats write so a flush coinciding with a refill leaves the line invalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (en) begin
      if (clear)   valid_q        <= '0;
      else if (we) valid_q[waddr] <= 1'b1;
    end
  end

  // NOTE: tag/data arrays are deliberately not reset; the valid bits alone gate every hit.
  always_ff @(posedge clk) begin
    if (!rst && en && we && !clear) begin
      tag_mem[waddr]  <= wtag;
      data_mem[waddr] <= wdata;
    end
  end

  assign rvalid = valid_q[raddr];
  assign rtag   = tag_mem[raddr];
  assign rdata  = data_mem[raddr];

endmodule

// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache with a blocking refill FSM.
// Defining ICACHE_STAT_EN adds hit/miss counter outputs.
module icache
  import icache_pkg::*;
#(
  parameter int INDEX_W = DEFAULT_INDEX_W,
  parameter int ADDR_W  = INST_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  input  logic              flush_i,
  output logic              inst_valid_o,
  output logic [INST_W-1:0] inst_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_done_i,
  input  logic [INST_W-1:0] mem_inst_i
`ifdef ICACHE_STAT_EN
  ,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o
`endif
);

  localparam int TAG_W = ADDR_W - INDEX_W - 2;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   miss_addr_q;
  logic [INST_W-1:0]   resp_word_q;
  logic                flushed_q;   // flush seen during the current MISS
  logic                resp_drop_q; // refill was discarded, suppress RESP

  logic [INDEX_W-1:0]  lookup_idx;
  logic [TAG_W-1:0]    lookup_tag;
  logic                rd_valid;
  logic [TAG_W-1:0]    rd_tag;
  logic [INST_W-1:0]   rd_data;
  logic                hit;
  logic                start_miss;
  logic                fill_we;
  logic                unused_addr_bits;

  assign lookup_idx       = if_addr_i[INDEX_W+1:2];
  assign lookup_tag       = if_addr_i[ADDR_W-1:INDEX_W+2];
  assign hit              = rd_valid && (rd_tag == lookup_tag);
  assign unused_addr_bits = ^if_addr_i[1:0];

  icache_tag_ram #(
    .INDEX_W(INDEX_W),
    .TAG_W  (TAG_W)
  ) u_tag_ram (
    .clk   (clk),
    .rst   (rst),
    .en    (rdy),
    .clear (flush_i),
    .we    (fill_we),
    .waddr (miss_addr_q[INDEX_W+1:2]),
    .wtag  (miss_addr_q[ADDR_W-1:INDEX_W+2]),
    .wdata (mem_inst_i),
    .raddr (lookup_idx),
    .rvalid(rd_valid),
    .rtag  (rd_tag),
    .rdata (rd_data)
  );

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_d      = state_q;
    inst_valid_o = 1'b0;
    inst_o       = '0;
    start_miss   = 1'b0;
    fill_we      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (if_req_i) begin
          if (hit && !flush_i) begin
            inst_valid_o = 1'b1;
            inst_o       = rd_data;
          end else begin
            start_miss = 1'b1;
            state_d    = S_MISS;
          end
        end
      end
      S_MISS: begin
        if (mem_done_i) begin
          fill_we = !flush_i && !flushed_q;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        if (if_req_i && !resp_drop_q &&
            (if_addr_i[ADDR_W-1:2] == miss_addr_q[ADDR_W-1:2])) begin
          inst_valid_o = 1'b1;
          inst_o       = resp_word_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      miss_addr_q <= '0;
      resp_word_q <= '0;
      flushed_q   <= 1'b0;
      resp_drop_q <= 1'b0;
    end else if (rdy) begin
      state_q <= state_d;
      if (start_miss) begin
        miss_addr_q <= {if_addr_i[ADDR_W-1:2], 2'b00};
        flushed_q   <= 1'b0;
      end
      if (state_q == S_MISS) begin
        if (flush_i) flushed_q <= 1'b1;
        if (mem_done_i) begin
          resp_word_q <= mem_inst_i;
          resp_drop_q <= flush_i || flushed_q;
        end
      end
    end
  end

  assign mem_req_o  = (state_q == S_MISS);
  assign mem_addr_o = miss_addr_q;

`ifdef ICACHE_STAT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else if (rdy && state_q == S_IDLE) begin
      if (inst_valid_o) hit_cnt_o  <= hit_cnt_o + 32'd1;
      if (start_miss)   miss_cnt_o <= miss_cnt_o + 32'd1;
    end
  end
`endif

endmodule
